// File: rtl/mips_isa_pkg.sv
// ISA constants and the request-to-word encoder shared with the main decoder.
// Pure combinational helpers; no state lives here.
package mips_isa_pkg;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_ADDI  = 3'd3,
    K_J     = 3'd4,
    K_BEQ   = 3'd5
  } instr_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_req_t;

  function automatic logic kind_legal(input logic [2:0] kind);
    return kind <= K_BEQ;
  endfunction

  // Fields a kind does not use are ignored; illegal kinds encode to zero.
  function automatic logic [31:0] encode(input instr_req_t req);
    logic [31:0] w;
    w = '0;
    case (req.kind)
      K_RTYPE: w = {OP_RTYPE, req.rs, req.rt, req.rd, req.shamt, req.funct};
      K_LW:    w = {OP_LW,    req.rs, req.rt, req.imm};
      K_SW:    w = {OP_SW,    req.rs, req.rt, req.imm};
      K_ADDI:  w = {OP_ADDI,  req.rs, req.rt, req.imm};
      K_J:     w = {OP_J,     req.target};
      K_BEQ:   w = {OP_BEQ,   req.rs, req.rt, req.imm};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is registered storage, visible the cycle after push.
// Backpressure: push ignored when full (even with a concurrent pop), pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty; DEPTH is a power of two.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes instruction requests into MIPS words tagged with sequential imem addresses.
// Latency 1 cycle into an empty FIFO; in_ready drops when full or during clear.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_kind,
  input  logic [4:0]                in_rs,
  input  logic [4:0]                in_rt,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_shamt,
  input  logic [5:0]                in_funct,
  input  logic [15:0]               in_imm,
  input  logic [25:0]               in_target,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_illegal
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  instr_req_t         req;
  logic               accept;
  logic               legal;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  addr_ctr;
  logic [ADDR_W+31:0] fifo_head;
  logic               fifo_empty;
  logic               fifo_full;

  assign req = '{kind: in_kind, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                 funct: in_funct, imm: in_imm, target: in_target};

  // Illegal kinds still complete the handshake so the loader never stalls on them.
  assign in_ready = !fifo_full && !clear;
  assign accept   = in_valid && in_ready;
  assign legal    = kind_legal(in_kind);
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (ADDR_W + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data ({addr_ctr, encode(req)}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? fifo_head[31:0] : '0;
  assign out_addr  = out_valid ? fifo_head[ADDR_W+31:32] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_ctr    <= BASE;
      err_illegal <= 1'b0;
    end else if (clear) begin
      addr_ctr    <= BASE;
      err_illegal <= 1'b0;
    end else begin
      if (push)            addr_ctr    <= addr_ctr + ADDR_W'(1);
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: spec vectors, backpressure/illegal/wrap/reset sequences, random traffic vs a queue model.
module tb_mips_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, out_valid, out_ready, err_illegal;
  logic [2:0]  in_kind, count;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .err_illegal(err_illegal)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int addr; logic [31:0] instr; } exp_t;
  exp_t q[$];
  int   m_addr = 0;
  bit   m_err  = 0;

  typedef struct {
    bit          clr;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_instr;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t vecs[6];

  // Word built by weighting each field with its bit position.
  function automatic logic [31:0] ref_encode(input logic [2:0] kind, input logic [4:0] rs, rt, rd, shamt,
                                             input logic [5:0] funct, input logic [15:0] imm,
                                             input logic [25:0] target);
    longint unsigned w, ops, rr;
    rr = 64'(rs) * 2097152 + 64'(rt) * 65536;
    case (kind)
      3'd0: begin ops = 0;  w = rr + 64'(rd) * 2048 + 64'(shamt) * 64 + 64'(funct); end
      3'd1: begin ops = 35; w = ops * 67108864 + rr + 64'(imm); end
      3'd2: begin ops = 43; w = ops * 67108864 + rr + 64'(imm); end
      3'd3: begin ops = 8;  w = ops * 67108864 + rr + 64'(imm); end
      3'd4: begin ops = 2;  w = ops * 67108864 + 64'(target); end
      3'd5: begin ops = 4;  w = ops * 67108864 + rr + 64'(imm); end
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output with the model, then advance the model and the DUT by one edge.
  task automatic step();
    bit acc;
    #1;
    check("in_ready",    64'(in_ready),    64'((q.size() < DEPTH) && !clear));
    check("count",       64'(count),       64'(q.size()));
    check("out_valid",   64'(out_valid),   64'(q.size() > 0));
    check("out_instr",   64'(out_instr),   q.size() > 0 ? 64'(q[0].instr) : 64'd0);
    check("out_addr",    64'(out_addr),    q.size() > 0 ? 64'(q[0].addr)  : 64'd0);
    check("err_illegal", 64'(err_illegal), 64'(m_err));
    if (clear) begin
      q.delete();
      m_addr = 0;
      m_err  = 0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        if (in_kind <= 3'd5) begin
          q.push_back('{m_addr, ref_encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target)});
          m_addr = (m_addr + 1) % 256;
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] k, input logic [4:0] rs, rt, rd, sh, input logic [5:0] f,
                         input logic [15:0] imm, input logic [25:0] tgt);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = f; in_imm = imm; in_target = tgt;
  endtask

  task automatic rand_req(input bit legal_only);
    set_req(legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7)),
            5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd0, 5'd1,  5'd2, 5'd3,  5'd0, 6'h20, 16'h0000, 26'h0,       32'h00221820, 8'd0};
    vecs[1] = '{1'b1, 3'd1, 5'd29, 5'd8, 5'd31, 5'd7, 6'h3f, 16'h0004, 26'h3ffffff, 32'h8FA80004, 8'd0};
    vecs[2] = '{1'b0, 3'd2, 5'd29, 5'd9, 5'd0,  5'd0, 6'h00, 16'h0008, 26'h0,       32'hAFA90008, 8'd1};
    vecs[3] = '{1'b0, 3'd3, 5'd0,  5'd8, 5'd5,  5'd9, 6'h11, 16'hFFFF, 26'h1234567, 32'h2008FFFF, 8'd2};
    vecs[4] = '{1'b0, 3'd4, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hFFFF, 26'h0100000, 32'h08100000, 8'd3};
    vecs[5] = '{1'b0, 3'd5, 5'd1,  5'd2, 5'd0,  5'd0, 6'h00, 16'h0003, 26'h0,       32'h10220003, 8'd4};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    #12 reset = 1'b0;
    @(posedge clk); #1;
    step();

    // Known encodings, each pushed then held at the head before popping.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr) do_clear();
      set_req(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt,
              vecs[i].funct, vecs[i].imm, vecs[i].target);
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("tbl_instr", 64'(out_instr), 64'(vecs[i].exp_instr));
      check("tbl_addr",  64'(out_addr),  64'(vecs[i].exp_addr));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    // Backpressure: fifth word blocked while full, and full+pop still blocks a push.
    do_clear();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(3'd0, 5'd1, 5'd2, 5'(k), 5'd0, 6'h20, 16'd0, 26'd0);
      step();
    end
    check("bp_ready_full", 64'(in_ready), 64'd0);
    check("bp_count_full", 64'(count), 64'd4);
    set_req(3'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20, 16'd0, 26'd0);
    step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bp_drained", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Illegal kind between two legal words: no address gap, sticky error until clear.
    do_clear();
    in_valid = 1'b1;
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0); step();
    set_req(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0); step();
    set_req(3'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 16'd0, 26'd0); step();
    in_valid = 1'b0;
    check("ill_err",   64'(err_illegal), 64'd1);
    check("ill_count", 64'(count), 64'd2);
    check("ill_addr0", 64'(out_addr), 64'd0);
    out_ready = 1'b1;
    step();
    check("ill_addr1", 64'(out_addr), 64'd1);
    step();
    out_ready = 1'b0;
    do_clear();
    check("ill_cleared", 64'(err_illegal), 64'd0);

    // Address wrap after 256 words, then reset in the middle of a burst.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 262; k++) begin
      rand_req(1'b1);
      step();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(1'b1);
      step();
    end
    reset = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count",     64'(count), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    q.delete(); m_addr = 0; m_err = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    step();

    // Random traffic including illegal kinds and occasional clears.
    for (int k = 0; k < 1500; k++) begin
      rand_req(1'b0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
